// File: rtl/ir_cmd_controller.sv
// Command manager behind ir_decoder: decoder reset/watchdog, NEC frame validation,
// repeat/hold tracking and a command FIFO. Define IR_ADDR_FILTER_EN to also require address == ADDR.
module ir_cmd_controller #(
    parameter logic [7:0]  ADDR         = 8'h00,
    parameter int unsigned HOLD_TIMEOUT = 11_000_000,
    parameter int unsigned WATCHDOG     = 12_000_000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] code_in,
    input  logic        new_code_in,
    input  logic [3:0]  dec_state_in,
    output logic        dec_rst_out,
    output logic [7:0]  cmd_out,
    output logic        cmd_repeat_out,
    output logic        cmd_valid_out,
    input  logic        cmd_ready_in,
    output logic        held_out,
    output logic [7:0]  drop_count_out,
    output logic [7:0]  err_count_out
);

    localparam int HOLD_W = $clog2(HOLD_TIMEOUT + 1);
    localparam int WD_W   = $clog2(WATCHDOG + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

`ifdef IR_ADDR_FILTER_EN
    localparam bit ADDR_FILTER = 1'b1;
`else
    localparam bit ADDR_FILTER = 1'b0;
`endif

    typedef enum logic {ST_DEC_RST, ST_RUN} state_t;

    state_t            state;
    logic              rst_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              wd_fire;

    logic              s1_stb;
    logic              s1_ok;
    logic [7:0]        s1_cmd;

    logic [HOLD_W-1:0] hold_cnt;
    logic [7:0]        last_cmd;

    logic [8:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt;

    logic              frame_ok;
    logic              push_req;
    logic              is_repeat;
    logic              full;
    logic              pop;
    logic              do_push;
    logic              drop;
    logic [1:0]        err_inc;
    logic [8:0]        err_sum;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        frame_ok = 1'b0;
        if ((code_in[23:16] == ~code_in[31:24]) && (code_in[7:0] == ~code_in[15:8]))
            frame_ok = !ADDR_FILTER || (code_in[31:24] == ADDR);
    end

    assign wd_fire   = (state == ST_RUN) && (dec_state_in != 4'd0) &&
                       (wd_cnt == WD_W'(WATCHDOG - 1));
    // A non-zero hold timer is what keeps last_cmd meaningful.
    assign push_req  = s1_stb && s1_ok;
    assign is_repeat = (hold_cnt != '0) && (s1_cmd == last_cmd);
    assign full      = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign pop       = cmd_valid_out && cmd_ready_in;
    assign do_push   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign err_inc   = 2'(s1_stb && !s1_ok) + 2'(wd_fire);
    assign err_sum   = {1'b0, err_count_out} + {7'd0, err_inc};

    assign cmd_valid_out  = (fifo_cnt != '0);
    assign cmd_out        = cmd_valid_out ? mem[rd_ptr][7:0] : 8'h00;
    assign cmd_repeat_out = cmd_valid_out && mem[rd_ptr][8];

    // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= ST_DEC_RST;
            rst_cnt     <= 1'b0;
            wd_cnt      <= '0;
            dec_rst_out <= 1'b1;
        end else begin
            case (state)
                ST_DEC_RST: begin
                    wd_cnt <= '0;
                    if (rst_cnt) begin
                        state       <= ST_RUN;
                        dec_rst_out <= 1'b0;
                        rst_cnt     <= 1'b0;
                    end else begin
                        rst_cnt <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (dec_state_in == 4'd0) begin
                        wd_cnt <= '0;
                    end else if (wd_fire) begin
                        state       <= ST_DEC_RST;
                        dec_rst_out <= 1'b1;
                        rst_cnt     <= 1'b0;
                        wd_cnt      <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= ST_DEC_RST;
            endcase
        end
    end

    // Validation stage: strobes arriving while the decoder is held in reset are discarded.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            s1_stb <= 1'b0;
            s1_ok  <= 1'b0;
            s1_cmd <= 8'h00;
        end else begin
            s1_stb <= new_code_in && (state == ST_RUN);
            s1_ok  <= frame_ok;
            s1_cmd <= code_in[15:8];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hold_cnt <= '0;
            last_cmd <= 8'h00;
            held_out <= 1'b0;
        end else if (push_req) begin
            hold_cnt <= HOLD_W'(HOLD_TIMEOUT);
            last_cmd <= s1_cmd;
            if (is_repeat)
                held_out <= 1'b1;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == HOLD_W'(1))
                held_out <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt <= fifo_cnt + CNT_W'(do_push) - CNT_W'(pop);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the count gates every read of it.
    always_ff @(posedge clk_in) begin
        if (do_push)
            mem[wr_ptr] <= {is_repeat, s1_cmd};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            drop_count_out <= 8'd0;
            err_count_out  <= 8'd0;
        end else begin
            if (drop && (drop_count_out != 8'hFF))
                drop_count_out <= drop_count_out + 8'd1;
            err_count_out <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end

endmodule

// File: doc/ir_cmd_controller.md
# ir_cmd_controller

Sequencing and command-management block that sits directly behind `ir_decoder`. It:
- owns the decoder's reset;
- watchdogs the decoder for stuck frames;
- validates each captured 32-bit NEC frame;
- classifies held-button repeats;
- buffers accepted commands in a small FIFO for downstream game/UI logic via a valid/ready handshake.

## Interface

Parameters:
- `ADDR`, 8'h00: expected NEC address byte.
- `HOLD_TIMEOUT`, 11_000_000: cycles (110 ms at 100 MHz) after an accepted frame during which an identical frame counts as a repeat.
- `WATCHDOG`, 12_000_000: maximum consecutive cycles the decoder may sit outside IDLE before it is force-reset.
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.

Ports:
- `clk_in` input 1: 100 MHz system clock.
- `rst_in` input 1: asynchronous, active-low reset.
- `code_in` input 32: decoder `code_out`.
- `new_code_in` input 1: decoder `new_code_out`, single-cycle strobe.
- `dec_state_in` input 4: decoder `state_out`; 0 = IDLE.
- `dec_rst_out` output 1: active-high reset to the decoder's `rst_in`.
- `cmd_out` output 8: FIFO head command byte.
- `cmd_repeat_out` output 1: FIFO head repeat flag.
- `cmd_valid_out` output 1: FIFO non-empty.
- `cmd_ready_in` input 1: consumer accepts head this cycle.
- `held_out` output 1: button currently held (repeat stream active).
- `drop_count_out` output 8: saturating count of frames dropped on FIFO full.
- `err_count_out` output 8: saturating count of invalid frames plus watchdog resets.

## Operation

- Frame layout, MSB first: [31:24] address A, [23:16] ~A, [15:8] command C, [7:0] ~C.
- A frame is valid iff `code_in[23:16] == ~code_in[31:24]` and `code_in[7:0] == ~code_in[15:8]`. Address filtering applies only when compiled in (see Configuration).
- Control FSM:
  - DEC_RST: `dec_rst_out`=1 for exactly 2 cycles, then go to RUN.
  - RUN: watchdog and frame handling are active. Watchdog expiry goes to DEC_RST.
  - Entered at reset and on watchdog expiry.
- Watchdog:
  - Counter increments each RUN cycle while `dec_state_in != 0`.
  - Clears when `dec_state_in == 0` and in DEC_RST.
  - Reaching WATCHDOG → DEC_RST and `err_count_out`+1.
- Frame handling, on `new_code_in` in RUN:
  - Invalid frame → `err_count_out`+1, no push.
  - Valid frame → repeat = (hold timer ≠ 0 and C == last_cmd).
  - Push {repeat, C}. last_cmd ← C. Hold timer reloads to HOLD_TIMEOUT.
  - If repeat, `held_out` ← 1.
- Hold timer decrements to 0. On the 1→0 transition, `held_out` ← 0 and last_cmd is invalidated.
- FIFO:
  - Pop when `cmd_valid_out && cmd_ready_in`.
  - Push while full with no pop that cycle → frame dropped, `drop_count_out`+1. The hold timer and last_cmd still update.
  - Push and pop in the same cycle while full → both occur; no drop.
- Both counters saturate at 255.
- `new_code_in` during DEC_RST is ignored.

## Timing

- Reset values, asserted and held while `rst_in`=0:
  - `dec_rst_out`=1
  - `cmd_out`=0, `cmd_repeat_out`=0, `cmd_valid_out`=0
  - `held_out`=0
  - both counters 0
  - FIFO empty, hold timer 0, FSM in DEC_RST.
- After `rst_in` rises, `dec_rst_out` stays 1 for 2 rising edges, then drops to 0.
- `new_code_in` in cycle N: validation is registered at the edge ending N, and the FIFO write occurs at the edge ending N+1.
- If the FIFO was empty, `cmd_valid_out`=1 in cycle N+2. Counters update at the edge ending N+1.
- `cmd_out`/`cmd_repeat_out` are stable while `cmd_valid_out`=1 and `cmd_ready_in`=0.
- Throughput: one push per cycle, one pop per cycle.
- Watchdog: on the cycle the count reaches WATCHDOG, `dec_rst_out` goes high for the next 2 cycles.

## Configuration

- `IR_ADDR_FILTER_EN` defined: a valid frame additionally requires `code_in[31:24] == ADDR`. A mismatch counts as invalid (`err_count_out`+1, no push).
- Not defined: any address is accepted, and ADDR is unused.

## Test plan

Defaults throughout, with HOLD_TIMEOUT=1000 and WATCHDOG=500 for sim.

- Reset release: `dec_rst_out` high for 2 cycles then 0. All other outputs 0.
- Single frame: `code_in`=32'h00FF_A25D strobed, `cmd_ready_in`=0 → two cycles later `cmd_valid_out`=1, `cmd_out`=8'hA2, `cmd_repeat_out`=0. Assert ready → valid drops next cycle.
- Bad checksum: 32'h00FF_A25C → no push, `err_count_out`=1. With `IR_ADDR_FILTER_EN`, 32'h01FE_A25D also → `err_count_out`+1.
- Repeat/hold:
  - A25D twice, 300 cycles apart → second entry has `cmd_repeat_out`=1 and `held_out`=1.
  - `held_out` falls 1000 cycles after the second frame.
  - A third A25D after that → repeat=0.
- Overflow: 6 valid frames with ready low → 4 entries, `drop_count_out`=2. A frame with a simultaneous pop while full → no drop.
- Watchdog / async reset:
  - Hold `dec_state_in`=3 for 500 cycles → `dec_rst_out` pulses 2 cycles, `err_count_out`+1.
  - Pull `rst_in` low mid-FIFO-fill → all outputs clear immediately.
